// File: rtl/instr_aligner_pkg.sv
// Shared types and helpers for the instruction aligner: halfword width,
// alignment FSM encoding and the compact-instruction predicate used by the decoder too.
package instr_aligner_pkg;

    localparam int HW_W = 16;

    typedef enum logic [0:0] {
        ST_ALIGN  = 1'b0,
        ST_STREAM = 1'b1
    } align_state_e;

    function automatic logic compact_hw(input logic [HW_W-1:0] h);
        return (h[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/instr_aligner_hw_queue.sv
// Circular halfword buffer: pushes 0..FHW halfwords and pops 0..2 per cycle.
// Besides the current head it exposes the head view the buffer will have next cycle.
module instr_aligner_hw_queue
    import instr_aligner_pkg::*;
#(
    parameter int BUF_HW = 6,
    parameter int FHW    = 2,
    parameter int CNT_W  = $clog2(BUF_HW + 1),
    parameter int PN_W   = $clog2(FHW + 1)
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [PN_W-1:0]     push_n,
    input  logic [FHW*HW_W-1:0] push_data,
    input  logic [1:0]          pop_n,
    output logic [CNT_W-1:0]    count,
    output logic [HW_W-1:0]     hw0,
    output logic [CNT_W-1:0]    next_count,
    output logic [HW_W-1:0]     next_hw0,
    output logic [HW_W-1:0]     next_hw1
);

    localparam int PTR_W = (BUF_HW > 1) ? $clog2(BUF_HW) : 1;
    localparam int PI_W  = (FHW > 1) ? $clog2(FHW) : 1;

    logic [HW_W-1:0]  mem_r [BUF_HW];
    logic [PTR_W-1:0] head_r;
    logic [CNT_W-1:0] count_r;
    logic [HW_W-1:0]  push_hw_s [FHW];
    logic [HW_W-1:0]  nh_s [2];

    // Operands never exceed three buffer lengths, so two conditional subtracts wrap them.
    function automatic logic [PTR_W-1:0] wrap_idx(input int x);
        int y;
        y = x;
        y = (y >= BUF_HW) ? (y - BUF_HW) : y;
        y = (y >= BUF_HW) ? (y - BUF_HW) : y;
        return PTR_W'(y);
    endfunction

    assign count    = count_r;
    assign hw0      = mem_r[head_r];
    assign next_hw0 = nh_s[0];
    assign next_hw1 = nh_s[1];

    // Unpack the incoming halfwords and build next cycle's head view.
    always_comb begin
        int remain;
        int idx;
        for (int j = 0; j < FHW; j++) begin
            push_hw_s[j] = push_data[j*HW_W +: HW_W];
        end
        remain  = int'(count_r) - int'(pop_n);
        nh_s[0] = '0;
        nh_s[1] = '0;
        for (int k = 0; k < 2; k++) begin
            idx = k - remain;
            if (k < remain) begin
                nh_s[k] = mem_r[wrap_idx(int'(head_r) + int'(pop_n) + k)];
            end else if (idx < int'(push_n)) begin
                nh_s[k] = push_hw_s[PI_W'(idx)];
            end else begin
                nh_s[k] = '0;
            end
        end
        if (clear) begin
            next_count = '0;
        end else begin
            next_count = count_r - CNT_W'(pop_n) + CNT_W'(push_n);
        end
    end

    // Storage and pointers: writes land at head+count, pops advance the head.
    always_ff @(posedge clock) begin
        if (clear) begin
            head_r  <= '0;
            count_r <= '0;
        end else begin
            for (int i = 0; i < FHW; i++) begin
                if (i < int'(push_n)) begin
                    mem_r[wrap_idx(int'(head_r) + int'(count_r) + i)] <= push_hw_s[i];
                end
            end
            head_r  <= wrap_idx(int'(head_r) + int'(pop_n));
            count_r <= next_count;
        end
    end

endmodule

// File: rtl/instr_aligner.sv
// Instruction aligner: buffers fetch words as halfwords and hands whole 16/32-bit
// instructions with their PC to the decoder; owns the next fetch address.
module instr_aligner
    import instr_aligner_pkg::*;
#(
    parameter int          FETCH_BYTES = 4,
    parameter int          BUF_HW      = 6,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [31:0]              fetch_addr,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    input  logic [FETCH_BYTES*8-1:0] fetch_data,
    input  logic                     flush,
    input  logic [31:0]              flush_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instruction,
    output logic [31:0]              out_pc,
    output logic                     out_is_compact
);

    localparam int FHW    = FETCH_BYTES / 2;
    localparam int OFF_W  = $clog2(FETCH_BYTES);
    localparam int DROP_W = OFF_W - 1;
    localparam int CNT_W  = $clog2(BUF_HW + 1);
    localparam int PN_W   = $clog2(FHW + 1);

    localparam logic [31:0]       ADDR_MASK   = ~(32'(FETCH_BYTES) - 32'd1);
    localparam logic [31:0]       RESET_FETCH = RESET_PC & ADDR_MASK;
    localparam logic [DROP_W-1:0] RESET_DROP  = RESET_PC[OFF_W-1:1];

    align_state_e        state_r;
    logic [DROP_W-1:0]   drop_r;
    logic [31:0]         fetch_addr_r;
    logic [31:0]         pc_r;
    logic                out_valid_r;
    logic [31:0]         out_instruction_r;
    logic                out_is_compact_r;

    logic                fetch_fire_s;
    logic                out_fire_s;
    logic                clear_s;
    logic [DROP_W-1:0]   eff_drop_s;
    logic [PN_W-1:0]     push_n_s;
    logic [FETCH_BYTES*8-1:0] push_data_s;
    logic [1:0]          pop_n_s;
    logic [CNT_W-1:0]    count_s;
    logic [HW_W-1:0]     head_hw_s;
    logic [CNT_W-1:0]    next_count_s;
    logic [HW_W-1:0]     next_hw0_s;
    logic [HW_W-1:0]     next_hw1_s;
    logic                nv_s;
    logic                ncompact_s;
    logic [31:0]         ninst_s;

    assign clear_s         = reset || flush;
    assign fetch_ready     = (count_s <= CNT_W'(BUF_HW - FHW));
    assign fetch_addr      = fetch_addr_r;
    assign out_valid       = out_valid_r;
    assign out_instruction = out_instruction_r;
    assign out_pc          = pc_r;
    assign out_is_compact  = out_is_compact_r;

    // Handshakes and the halfwords handed to the queue; flush suppresses both transfers.
    always_comb begin
        fetch_fire_s = fetch_valid && fetch_ready && !flush;
        out_fire_s   = out_valid_r && out_ready && !flush;
        if (state_r == ST_ALIGN) begin
            eff_drop_s = drop_r;
        end else begin
            eff_drop_s = '0;
        end
        if (fetch_fire_s) begin
            push_n_s = PN_W'(FHW) - PN_W'(eff_drop_s);
        end else begin
            push_n_s = '0;
        end
        push_data_s = fetch_data >> {eff_drop_s, 4'b0000};
        if (out_fire_s) begin
            pop_n_s = compact_hw(head_hw_s) ? 2'd1 : 2'd2;
        end else begin
            pop_n_s = 2'd0;
        end
    end

    instr_aligner_hw_queue #(
        .BUF_HW (BUF_HW),
        .FHW    (FHW),
        .CNT_W  (CNT_W),
        .PN_W   (PN_W)
    ) u_queue (
        .clock      (clock),
        .clear      (clear_s),
        .push_n     (push_n_s),
        .push_data  (push_data_s),
        .pop_n      (pop_n_s),
        .count      (count_s),
        .hw0        (head_hw_s),
        .next_count (next_count_s),
        .next_hw0   (next_hw0_s),
        .next_hw1   (next_hw1_s)
    );

    // Decode next cycle's head so out_* can be registered with one cycle of latency.
    always_comb begin
        ncompact_s = compact_hw(next_hw0_s);
        nv_s = (next_count_s >= CNT_W'(1)) &&
               (ncompact_s || (next_count_s >= CNT_W'(2)));
        if (!nv_s) begin
            ninst_s = 32'h0;
        end else if (ncompact_s) begin
            ninst_s = {16'h0000, next_hw0_s};
        end else begin
            ninst_s = {next_hw1_s, next_hw0_s};
        end
    end

    // Control and output registers; reset and flush both restart alignment at a new PC.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r           <= ST_ALIGN;
            drop_r            <= RESET_DROP;
            fetch_addr_r      <= RESET_FETCH;
            pc_r              <= RESET_PC;
            out_valid_r       <= 1'b0;
            out_instruction_r <= 32'h0;
            out_is_compact_r  <= 1'b0;
        end else if (flush) begin
            state_r           <= ST_ALIGN;
            drop_r            <= flush_pc[OFF_W-1:1];
            fetch_addr_r      <= flush_pc & ADDR_MASK;
            pc_r              <= {flush_pc[31:1], 1'b0};
            out_valid_r       <= 1'b0;
            out_instruction_r <= 32'h0;
            out_is_compact_r  <= 1'b0;
        end else begin
            if (fetch_fire_s) begin
                fetch_addr_r <= fetch_addr_r + 32'(FETCH_BYTES);
                state_r      <= ST_STREAM;
            end
            if (out_fire_s) begin
                pc_r <= pc_r + (out_is_compact_r ? 32'd2 : 32'd4);
            end
            // A held instruction keeps its halfwords at the head, so reloading is stable.
            out_valid_r       <= nv_s;
            out_instruction_r <= ninst_s;
            out_is_compact_r  <= nv_s && ncompact_s;
        end
    end

endmodule

// File: tb/tb_instr_aligner.sv
// Self-checking bench: the reference derives buffer occupancy from (fetch_addr - pc)
// and expected instructions from a halfword memory image addressed by the PC.
module tb_instr_aligner;

    localparam int FB  = 4;
    localparam int BUF = 6;
    localparam int FHW = FB / 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        flush;
    logic [31:0] flush_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        out_is_compact;

    int tests = 0;
    int fails = 0;

    logic [15:0] hw_mem [256];
    logic [31:0] m_pc;
    logic [31:0] m_fa;

    always #5 clock = ~clock;

    instr_aligner #(.FETCH_BYTES(FB), .BUF_HW(BUF), .RESET_PC(32'h0)) dut (
        .clock           (clock),
        .reset           (reset),
        .fetch_addr      (fetch_addr),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .fetch_data      (fetch_data),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .out_is_compact  (out_is_compact)
    );

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        return hw_mem[a[8:1]];
    endfunction

    function automatic int m_count();
        logic [31:0] d;
        d = m_fa - m_pc;
        return int'($signed(d)) / 2;
    endfunction

    function automatic logic m_compact();
        logic [15:0] h;
        h = hw_at(m_pc);
        return h[1:0] != 2'b11;
    endfunction

    function automatic logic m_valid();
        int c;
        c = m_count();
        return (c >= 1) && (m_compact() || c >= 2);
    endfunction

    function automatic logic m_ready();
        int c;
        c = m_count();
        if (c < 0) c = 0;
        return (BUF - c) >= FHW;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [31:0] inst;
        chk("fetch_addr", fetch_addr, m_fa);
        chk("fetch_ready", {31'b0, fetch_ready}, {31'b0, m_ready()});
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid()});
        chk("out_pc", out_pc, m_pc);
        if (m_valid()) begin
            inst = m_compact() ? {16'h0, hw_at(m_pc)} : {hw_at(m_pc + 32'd2), hw_at(m_pc)};
            chk("out_instruction", out_instruction, inst);
            chk("out_is_compact", {31'b0, out_is_compact}, {31'b0, m_compact()});
        end
    endtask

    // One clock: drive inputs, advance the reference at the edge, check at the falling edge.
    task automatic step(input logic rst, input logic fv, input logic fl,
                        input logic [31:0] fpc, input logic ordy);
        logic ev, er, cp;
        reset       = rst;
        fetch_valid = fv;
        flush       = fl;
        flush_pc    = fpc;
        out_ready   = ordy;
        fetch_data  = {hw_at(m_fa + 32'd2), hw_at(m_fa)};
        ev = m_valid();
        er = m_ready();
        cp = m_compact();
        @(posedge clock);
        if (rst) begin
            m_pc = 32'h0;
            m_fa = 32'h0;
        end else if (fl) begin
            m_pc = fpc & ~32'd1;
            m_fa = fpc & ~32'd3;
        end else begin
            if (ev && ordy) m_pc = m_pc + (cp ? 32'd2 : 32'd4);
            if (fv && er) m_fa = m_fa + 32'd4;
        end
        @(negedge clock);
        check_model();
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] fpc;
        reset = 1'b1; fetch_valid = 1'b0; flush = 1'b0; flush_pc = 32'h0;
        out_ready = 1'b0; fetch_data = 32'h0;
        m_pc = 32'h0; m_fa = 32'h0;
        for (int i = 0; i < 256; i++) hw_mem[i] = 16'h0000;

        // Reset and a single 32-bit instruction at address 0.
        hw_mem[0] = 16'h0093; hw_mem[1] = 16'h00A0;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t1_fetch_addr", fetch_addr, 32'h0);
        chk("t1_fetch_ready", {31'b0, fetch_ready}, 32'd1);
        chk("t1_out_valid", {31'b0, out_valid}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t2_inst", out_instruction, 32'h00A00093);
        chk("t2_compact", {31'b0, out_is_compact}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t2_fetch_addr", fetch_addr, 32'h4);

        // Two compact instructions in one word.
        step(1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
        hw_mem[8] = 16'h4501; hw_mem[9] = 16'h4585;
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t3_inst0", out_instruction, 32'h00004501);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t3_inst1", out_instruction, 32'h00004585);
        chk("t3_pc1", out_pc, 32'h12);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // 32-bit instruction straddling two fetch words.
        step(1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
        hw_mem[16] = 16'h4501; hw_mem[17] = 16'h0093;
        hw_mem[18] = 16'h00A0; hw_mem[19] = 16'h4501;
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t4_first", out_instruction, 32'h00004501);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t4_lone_upper", {31'b0, out_valid}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t4_straddle", out_instruction, 32'h00A00093);
        chk("t4_straddle_pc", out_pc, 32'h22);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t4_last_pc", out_pc, 32'h26);

        // Flush to a halfword-aligned target with fetch data offered in the same cycle.
        step(1'b0, 1'b1, 1'b1, 32'h106, 1'b0);
        hw_mem[8'h82] = 16'h4501; hw_mem[8'h83] = 16'h1234;
        chk("t5_fetch_addr", fetch_addr, 32'h104);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t5_inst", out_instruction, 32'h00001234);
        chk("t5_pc", out_pc, 32'h106);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t5_dropped", {31'b0, out_valid}, 32'd0);

        // Backpressure until the buffer fills, then drain.
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
        for (int i = 0; i < 6; i++) hw_mem[8'h20 + i] = i[0] ? 16'h4585 : 16'h4501;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t6_full", {31'b0, fetch_ready}, 32'd0);
        chk("t6_hold_inst", out_instruction, 32'h00004501);
        chk("t6_hold_pc", out_pc, 32'h40);
        chk("t6_fetch_addr", fetch_addr, 32'h4C);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            chk("t6_drain_pc", out_pc, 32'h40 + 32'(2 * (k + 1)));
        end

        // Randomized traffic over a random memory image, including flushes near 2^32.
        for (int i = 0; i < 256; i++) begin
            r = $urandom;
            hw_mem[i] = r[0] ? {r[16:3], 2'b11} : r[16:1];
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 199);
            fpc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 511));
            step(r == 32'd0, $urandom_range(0, 3) != 0, r < 32'd10, fpc,
                 $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
